// File: rtl/hyperbus_arbiter_if.sv
// hyperbus_arbiter_if: requester-side and hyperbus_fifo-side signals of the arbiter
interface hyperbus_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NREQ-1:0]            req_rrq;
    logic [NREQ-1:0]            req_wrq;
    logic [NREQ*ADDR_WIDTH-1:0] req_adr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdat;
    logic [NREQ-1:0]            req_gnt;
    logic [DATA_WIDTH-1:0]      req_rdat;
    logic [NREQ-1:0]            req_rvalid;
    logic                       fifo_rrq;
    logic                       fifo_wrq;
    logic [ADDR_WIDTH-1:0]      fifo_adr;
    logic [DATA_WIDTH-1:0]      fifo_tx_dat;
    logic                       fifo_tx_ready;
    logic [DATA_WIDTH-1:0]      fifo_rx_dat;
    logic                       fifo_rx_valid;

    modport slave (
        input  req_rrq, req_wrq, req_adr, req_wdat, fifo_tx_ready, fifo_rx_dat, fifo_rx_valid,
        output req_gnt, req_rdat, req_rvalid, fifo_rrq, fifo_wrq, fifo_adr, fifo_tx_dat
    );

    modport master (
        output req_rrq, req_wrq, req_adr, req_wdat, fifo_tx_ready, fifo_rx_dat, fifo_rx_valid,
        input  req_gnt, req_rdat, req_rvalid, fifo_rrq, fifo_wrq, fifo_adr, fifo_tx_dat
    );
endinterface

// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: round-robin read/write arbiter in front of hyperbus_fifo with read-tag routing
module hyperbus_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUT    = 3,
    parameter int WR_HOLD    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    hyperbus_arbiter_if.slave            bus,
    output logic [$clog2(MAX_OUT+1)-1:0] rd_outstanding,
    output logic                         err_unexp
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int HW = WR_HOLD > 1 ? $clog2(WR_HOLD) : 1;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_HOLD = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [PW-1:0]         rr_q, rr_d, sel, idx;
    logic                  found, sel_rd, go, push, pop;
    logic [NREQ-1:0]       rd_el, wr_el;
    logic [NREQ-1:0]       gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic                  rrq_q, rrq_d, wrq_q, wrq_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] tdat_q, tdat_d, rdat_q, rdat_d;
    logic [PW-1:0]         tags_q [MAX_OUT];
    logic [PW-1:0]         tags_d [MAX_OUT];
    logic [TW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign rd_el = bus.req_rrq & {NREQ{cnt_q < CW'(MAX_OUT)}};
    assign wr_el = bus.req_wrq & {NREQ{bus.fifo_tx_ready}};

    // Round-robin search for the first eligible requester at or after rr_ptr; reads beat writes
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        sel_rd = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_q) + k) % NREQ);
            if (!found && (rd_el[idx] || wr_el[idx])) begin
                found  = 1'b1;
                sel    = idx;
                sel_rd = rd_el[idx];
            end
        end
    end

    // Grant, write-holdoff FSM, tag FIFO and read-data routing next-state
    always_comb begin
        go       = state_q == ST_IDLE && gnt_q == '0 && found;
        push     = go && sel_rd;
        pop      = bus.fifo_rx_valid && cnt_q != '0;
        gnt_d    = go ? NREQ'(1) << sel : '0;
        rrq_d    = push;
        wrq_d    = go && !sel_rd;
        adr_d    = go ? bus.req_adr[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        tdat_d   = go ? bus.req_wdat[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
        rr_d     = go ? (sel == PW'(NREQ - 1) ? '0 : sel + 1'b1) : rr_q;
        state_d  = state_q;
        hold_d   = hold_q;
        if (wrq_d) begin
            state_d = ST_WR_HOLD;
            hold_d  = HW'(WR_HOLD - 1);
        end else if (state_q == ST_WR_HOLD) begin
            state_d = hold_q == '0 ? ST_WR_WAIT : ST_WR_HOLD;
            hold_d  = hold_q - 1'b1;
        end else if (state_q == ST_WR_WAIT && bus.fifo_tx_ready) begin
            state_d = ST_IDLE;
        end
        tags_d   = tags_q;
        if (push) tags_d[wp_q] = sel;
        wp_d     = push ? (wp_q == TW'(MAX_OUT - 1) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d     = pop ? (rp_q == TW'(MAX_OUT - 1) ? '0 : rp_q + 1'b1) : rp_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        rvalid_d = pop ? NREQ'(1) << tags_q[rp_q] : '0;
        rdat_d   = pop ? bus.fifo_rx_dat : rdat_q;
        err_d    = err_q | (bus.fifo_rx_valid && cnt_q == '0);
    end

    // State registers; reset clears every output and empties the tag FIFO at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            rr_q     <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rrq_q    <= 1'b0;
            wrq_q    <= 1'b0;
            err_q    <= 1'b0;
            adr_q    <= '0;
            tdat_q   <= '0;
            rdat_q   <= '0;
            tags_q   <= '{default: '0};
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rrq_q    <= rrq_d;
            wrq_q    <= wrq_d;
            err_q    <= err_d;
            adr_q    <= adr_d;
            tdat_q   <= tdat_d;
            rdat_q   <= rdat_d;
            tags_q   <= tags_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_gnt     = gnt_q;
    assign bus.req_rvalid  = rvalid_q;
    assign bus.req_rdat    = rdat_q;
    assign bus.fifo_rrq    = rrq_q;
    assign bus.fifo_wrq    = wrq_q;
    assign bus.fifo_adr    = adr_q;
    assign bus.fifo_tx_dat = tdat_q;
    assign rd_outstanding  = cnt_q;
    assign err_unexp       = err_q;
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb_hyperbus_arbiter: directed self-checking bench for hyperbus_arbiter
module tb_hyperbus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rd_outstanding;
    logic       err_unexp;
    int         tests = 0;
    int         fails = 0;

    hyperbus_arbiter_if #(.NREQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    hyperbus_arbiter #(.NREQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUT(3), .WR_HOLD(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .rd_outstanding(rd_outstanding),
        .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_rrq = '0;
        bus.req_wrq = '0;
        bus.req_adr = '0;
        bus.req_wdat = '0;
        bus.fifo_tx_ready = 1'b1;
        bus.fifo_rx_dat = '0;
        bus.fifo_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.req_gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: got %b exp %b", bus.req_gnt, 4'b0000); end
        tests++; if (bus.req_rvalid !== 4'b0000) begin fails++; $display("FAIL rst_rvalid: got %b exp %b", bus.req_rvalid, 4'b0000); end
        tests++; if ({bus.fifo_rrq, bus.fifo_wrq} !== 2'b00) begin fails++; $display("FAIL rst_cmd: got %b exp %b", {bus.fifo_rrq, bus.fifo_wrq}, 2'b00); end
        tests++; if (bus.fifo_adr !== 32'h0 || bus.fifo_tx_dat !== 32'h0 || bus.req_rdat !== 32'h0) begin fails++; $display("FAIL rst_data: got adr %h tx %h rd %h exp 0", bus.fifo_adr, bus.fifo_tx_dat, bus.req_rdat); end
        tests++; if (rd_outstanding !== 2'd0 || err_unexp !== 1'b0) begin fails++; $display("FAIL rst_cnt: got %0d/%b exp 0/0", rd_outstanding, err_unexp); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.req_rrq = 4'b0100;
        bus.req_adr[2*32 +: 32] = 32'h100;
        step();
        tests++; if (bus.fifo_rrq !== 1'b1 || bus.fifo_wrq !== 1'b0) begin fails++; $display("FAIL sr_cmd: got rrq %b wrq %b exp 1 0", bus.fifo_rrq, bus.fifo_wrq); end
        tests++; if (bus.fifo_adr !== 32'h100) begin fails++; $display("FAIL sr_adr: got %h exp %h", bus.fifo_adr, 32'h100); end
        tests++; if (bus.req_gnt !== 4'b0100) begin fails++; $display("FAIL sr_gnt: got %b exp %b", bus.req_gnt, 4'b0100); end
        tests++; if (rd_outstanding !== 2'd1) begin fails++; $display("FAIL sr_out: got %0d exp 1", rd_outstanding); end
        bus.req_rrq = '0;
        step();
        tests++; if (bus.req_gnt !== 4'b0000 || bus.fifo_rrq !== 1'b0) begin fails++; $display("FAIL sr_pulse: got gnt %b rrq %b exp 0000 0", bus.req_gnt, bus.fifo_rrq); end
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'hDEADBEEF;
        step();
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_rvalid !== 4'b0100) begin fails++; $display("FAIL sr_rvalid: got %b exp %b", bus.req_rvalid, 4'b0100); end
        tests++; if (bus.req_rdat !== 32'hDEADBEEF) begin fails++; $display("FAIL sr_rdat: got %h exp %h", bus.req_rdat, 32'hDEADBEEF); end
        tests++; if (rd_outstanding !== 2'd0) begin fails++; $display("FAIL sr_out0: got %0d exp 0", rd_outstanding); end
        step();
        tests++; if (bus.req_rvalid !== 4'b0000) begin fails++; $display("FAIL sr_rvalid_pulse: got %b exp %b", bus.req_rvalid, 4'b0000); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rv;
        do_reset();
        bus.req_rrq = 4'b1111;
        step();
        tests++; if (bus.req_gnt !== 4'b0001) begin fails++; $display("FAIL rr_g0: got %b exp %b", bus.req_gnt, 4'b0001); end
        bus.req_rrq[0] = 1'b0;
        step();
        tests++; if (bus.req_gnt !== 4'b0000) begin fails++; $display("FAIL rr_gap: got %b exp %b", bus.req_gnt, 4'b0000); end
        step();
        tests++; if (bus.req_gnt !== 4'b0010) begin fails++; $display("FAIL rr_g1: got %b exp %b", bus.req_gnt, 4'b0010); end
        bus.req_rrq[1] = 1'b0;
        step();
        step();
        tests++; if (bus.req_gnt !== 4'b0100) begin fails++; $display("FAIL rr_g2: got %b exp %b", bus.req_gnt, 4'b0100); end
        tests++; if (rd_outstanding !== 2'd3) begin fails++; $display("FAIL rr_full: got %0d exp 3", rd_outstanding); end
        bus.req_rrq[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (bus.req_gnt !== 4'b0000) begin fails++; $display("FAIL rr_stall%0d: got %b exp %b", i, bus.req_gnt, 4'b0000); end
        end
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'hA0;
        step();
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_rvalid !== 4'b0001 || bus.req_rdat !== 32'hA0) begin fails++; $display("FAIL rr_ret0: got %b %h exp 0001 a0", bus.req_rvalid, bus.req_rdat); end
        tests++; if (bus.req_gnt !== 4'b0000 || rd_outstanding !== 2'd2) begin fails++; $display("FAIL rr_pop: got gnt %b out %0d exp 0000 2", bus.req_gnt, rd_outstanding); end
        step();
        tests++; if (bus.req_gnt !== 4'b1000 || rd_outstanding !== 2'd3) begin fails++; $display("FAIL rr_g3: got gnt %b out %0d exp 1000 3", bus.req_gnt, rd_outstanding); end
        bus.req_rrq[3] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            bus.fifo_rx_valid = 1'b1;
            bus.fifo_rx_dat = 32'hA0 + i;
            step();
            exp_rv = 4'b0001 << i;
            tests++; if (bus.req_rvalid !== exp_rv || bus.req_rdat !== 32'hA0 + i) begin fails++; $display("FAIL rr_ret%0d: got %b %h exp %b %h", i, bus.req_rvalid, bus.req_rdat, exp_rv, 32'hA0 + i); end
        end
        bus.fifo_rx_valid = 1'b0;
        tests++; if (rd_outstanding !== 2'd0 || err_unexp !== 1'b0) begin fails++; $display("FAIL rr_drain: got %0d/%b exp 0/0", rd_outstanding, err_unexp); end
    endtask

    task automatic test_write();
        int nwr;
        do_reset();
        bus.req_wrq = 4'b0010;
        bus.req_adr[1*32 +: 32] = 32'h40;
        bus.req_wdat[1*32 +: 32] = 32'h12345678;
        step();
        nwr = int'(bus.fifo_wrq);
        tests++; if (bus.fifo_wrq !== 1'b1 || bus.fifo_rrq !== 1'b0 || bus.req_gnt !== 4'b0010) begin fails++; $display("FAIL wr_cmd: got wrq %b rrq %b gnt %b exp 1 0 0010", bus.fifo_wrq, bus.fifo_rrq, bus.req_gnt); end
        tests++; if (bus.fifo_adr !== 32'h40 || bus.fifo_tx_dat !== 32'h12345678) begin fails++; $display("FAIL wr_data: got %h %h exp 40 12345678", bus.fifo_adr, bus.fifo_tx_dat); end
        bus.req_wrq = '0;
        bus.fifo_tx_ready = 1'b0;
        bus.req_rrq = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            step();
            nwr += int'(bus.fifo_wrq);
            tests++; if (bus.req_gnt !== 4'b0000) begin fails++; $display("FAIL wr_block%0d: got %b exp %b", i, bus.req_gnt, 4'b0000); end
        end
        bus.fifo_tx_ready = 1'b1;
        step();
        nwr += int'(bus.fifo_wrq);
        tests++; if (bus.req_gnt !== 4'b0000) begin fails++; $display("FAIL wr_toidle: got %b exp %b", bus.req_gnt, 4'b0000); end
        step();
        nwr += int'(bus.fifo_wrq);
        tests++; if (bus.req_gnt !== 4'b0001 || bus.fifo_rrq !== 1'b1) begin fails++; $display("FAIL wr_after: got gnt %b rrq %b exp 0001 1", bus.req_gnt, bus.fifo_rrq); end
        tests++; if (nwr !== 1) begin fails++; $display("FAIL wr_pulses: got %0d exp 1", nwr); end
        bus.req_rrq = '0;
    endtask

    task automatic test_unexpected();
        do_reset();
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'h55;
        step();
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_rvalid !== 4'b0000) begin fails++; $display("FAIL ux_rvalid: got %b exp %b", bus.req_rvalid, 4'b0000); end
        tests++; if (err_unexp !== 1'b1) begin fails++; $display("FAIL ux_err: got %b exp 1", err_unexp); end
        tests++; if (bus.req_rdat !== 32'h0 || rd_outstanding !== 2'd0) begin fails++; $display("FAIL ux_drop: got %h %0d exp 0 0", bus.req_rdat, rd_outstanding); end
        repeat (3) step();
        tests++; if (err_unexp !== 1'b1) begin fails++; $display("FAIL ux_sticky: got %b exp 1", err_unexp); end
    endtask

    task automatic test_coincide();
        do_reset();
        bus.req_rrq = 4'b0011;
        step();
        bus.req_rrq[0] = 1'b0;
        step();
        step();
        bus.req_rrq[1] = 1'b0;
        tests++; if (rd_outstanding !== 2'd2) begin fails++; $display("FAIL co_pre: got %0d exp 2", rd_outstanding); end
        step();
        bus.req_rrq[2] = 1'b1;
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'hC0;
        step();
        bus.req_rrq[2] = 1'b0;
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_gnt !== 4'b0100 || bus.req_rvalid !== 4'b0001) begin fails++; $display("FAIL co_both: got gnt %b rv %b exp 0100 0001", bus.req_gnt, bus.req_rvalid); end
        tests++; if (rd_outstanding !== 2'd2 || bus.req_rdat !== 32'hC0) begin fails++; $display("FAIL co_cnt: got %0d %h exp 2 c0", rd_outstanding, bus.req_rdat); end
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'hC1;
        step();
        tests++; if (bus.req_rvalid !== 4'b0010 || bus.req_rdat !== 32'hC1) begin fails++; $display("FAIL co_ret1: got %b %h exp 0010 c1", bus.req_rvalid, bus.req_rdat); end
        bus.fifo_rx_dat = 32'hC2;
        step();
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_rvalid !== 4'b0100 || bus.req_rdat !== 32'hC2 || rd_outstanding !== 2'd0) begin fails++; $display("FAIL co_ret2: got %b %h %0d exp 0100 c2 0", bus.req_rvalid, bus.req_rdat, rd_outstanding); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_rrq = 4'b0011;
        bus.req_adr[1*32 +: 32] = 32'h80;
        step();
        bus.req_rrq[0] = 1'b0;
        step();
        step();
        bus.req_rrq[1] = 1'b0;
        tests++; if (bus.req_gnt !== 4'b0010 || bus.fifo_adr !== 32'h80 || rd_outstanding !== 2'd2) begin fails++; $display("FAIL ar_pre: got %b %h %0d exp 0010 80 2", bus.req_gnt, bus.fifo_adr, rd_outstanding); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.req_gnt !== 4'b0000 || bus.fifo_rrq !== 1'b0 || bus.fifo_adr !== 32'h0) begin fails++; $display("FAIL ar_async: got %b %b %h exp 0000 0 0", bus.req_gnt, bus.fifo_rrq, bus.fifo_adr); end
        tests++; if (rd_outstanding !== 2'd0) begin fails++; $display("FAIL ar_cnt: got %0d exp 0", rd_outstanding); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.fifo_rx_valid = 1'b1;
        bus.fifo_rx_dat = 32'h77;
        step();
        bus.fifo_rx_valid = 1'b0;
        tests++; if (bus.req_rvalid !== 4'b0000 || err_unexp !== 1'b1) begin fails++; $display("FAIL ar_stale: got rv %b err %b exp 0000 1", bus.req_rvalid, err_unexp); end
        bus.req_rrq = 4'b1111;
        step();
        tests++; if (bus.req_gnt !== 4'b0001) begin fails++; $display("FAIL ar_next: got %b exp %b", bus.req_gnt, 4'b0001); end
        bus.req_rrq = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_unexpected();
        test_coincide();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
